// File: rtl/uart_packet_tx.sv
// uart_packet_tx
// Sends a packet of up to NUM_BYTES bytes as back-to-back UART frames.
// Each frame has a start bit, 8 data bits (LSB first), an optional parity
// bit, and a stop bit. An optional idle-high gap separates the bytes.
// All outputs are registered and computed from the next state, so tx is
// glitch-free and lines up exactly with the state it represents.
module uart_packet_tx #(
   parameter int NUM_BYTES    = 14,
   parameter int CLKS_PER_BIT = 27,
   parameter int GAP_CYCLES   = 50000,
   parameter int PARITY_EN    = 0
) (
   input  logic                           clk_3125,
   input  logic                           rst,
   input  logic                           start,
   input  logic [8*NUM_BYTES-1:0]         data_flat,
   input  logic [$clog2(NUM_BYTES+1)-1:0] byte_count,
   input  logic                           parity_type,
   output logic                           tx,
   output logic                           busy,
   output logic                           byte_done,
   output logic                           done
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_BYTES);
   localparam logic [CW-1:0] ONE_LEFT  = CW'(1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      PARITY,
      STOP,
      GAP,
      FINISH
   } state_t;

   state_t                       state_reg, state_next;
   logic [NUM_BYTES-1:0][7:0]    data_reg;
   logic                         ptype_reg, ptype_next;
   logic [CW-1:0]                left_reg, left_next;
   logic [IW-1:0]                byte_idx_reg, byte_idx_next;
   logic [2:0]                   bit_idx_reg, bit_idx_next;
   logic [TW-1:0]                clk_cnt_reg, clk_cnt_next;
   logic [GW-1:0]                gap_cnt_reg, gap_cnt_next;
   logic                         tx_reg, tx_next;
   logic                         busy_reg, busy_next;
   logic                         done_reg, done_next;
   logic                         byte_done_reg, byte_done_next;

   logic                         accept;
   logic                         bit_tick;
   logic [CW-1:0]                count_clamped;
   logic [7:0]                   cur_byte;

   assign bit_tick      = (clk_cnt_reg == TICK_LAST);
   assign count_clamped = (byte_count > MAX_COUNT) ? MAX_COUNT : byte_count;

   assign tx        = tx_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign byte_done = byte_done_reg;

   // State, counters and output registers; reset aborts any packet and idles the line
   always_ff @(posedge clk_3125) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptype_reg     <= 1'b0;
         left_reg      <= '0;
         byte_idx_reg  <= '0;
         bit_idx_reg   <= '0;
         clk_cnt_reg   <= '0;
         gap_cnt_reg   <= '0;
         tx_reg        <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         byte_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ptype_reg     <= ptype_next;
         left_reg      <= left_next;
         byte_idx_reg  <= byte_idx_next;
         bit_idx_reg   <= bit_idx_next;
         clk_cnt_reg   <= clk_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         tx_reg        <= tx_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         byte_done_reg <= byte_done_next;
      end
   end

   // Payload snapshot, taken only at packet acceptance so later input changes are ignored
   always_ff @(posedge clk_3125) begin
      if (accept) begin
         data_reg <= data_flat;
      end
   end

   // Next-state logic: bit timing, byte sequencing and the inter-byte gap
   always_comb begin
      state_next     = state_reg;
      ptype_next     = ptype_reg;
      left_next      = left_reg;
      byte_idx_next  = byte_idx_reg;
      bit_idx_next   = bit_idx_reg;
      clk_cnt_next   = clk_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      byte_done_next = 1'b0;
      accept         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               accept        = 1'b1;
               ptype_next    = parity_type;
               left_next     = count_clamped;
               byte_idx_next = '0;
               bit_idx_next  = '0;
               clk_cnt_next  = '0;
               gap_cnt_next  = '0;
               // An empty packet skips framing and just signals completion
               state_next    = (count_clamped == '0) ? FINISH : START_BIT;
            end
         end

         START_BIT: begin
            if (bit_tick) begin
               clk_cnt_next = '0;
               bit_idx_next = '0;
               state_next   = DATA_BITS;
            end else begin
               clk_cnt_next = clk_cnt_reg + 1'b1;
            end
         end

         DATA_BITS: begin
            if (bit_tick) begin
               clk_cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + 1'b1;
            end
         end

         PARITY: begin
            if (bit_tick) begin
               clk_cnt_next = '0;
               state_next   = STOP;
            end else begin
               clk_cnt_next = clk_cnt_reg + 1'b1;
            end
         end

         STOP: begin
            if (bit_tick) begin
               clk_cnt_next   = '0;
               byte_done_next = 1'b1;
               if (left_reg == ONE_LEFT) begin
                  state_next = FINISH;
               end else begin
                  left_next     = left_reg - 1'b1;
                  byte_idx_next = byte_idx_reg + 1'b1;
                  bit_idx_next  = '0;
                  gap_cnt_next  = '0;
                  state_next    = (GAP_CYCLES > 0) ? GAP : START_BIT;
               end
            end else begin
               clk_cnt_next = clk_cnt_reg + 1'b1;
            end
         end

         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               clk_cnt_next = '0;
               state_next   = START_BIT;
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end

         FINISH: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Line level and status flags for the state about to be entered
   always_comb begin
      cur_byte = data_reg[byte_idx_next];
      case (state_next)
         START_BIT: tx_next = 1'b0;
         DATA_BITS: tx_next = cur_byte[bit_idx_next];
         PARITY:    tx_next = (^cur_byte) ^ ptype_next;
         default:   tx_next = 1'b1;
      endcase
      busy_next = (state_next != IDLE);
      done_next = (state_next == FINISH);
   end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Testbench for uart_packet_tx: three instances cover the plain, gapped and
// parity configurations. Expected bytes go into a scoreboard queue when a
// packet is launched and are popped as frames are decoded from tx.
module tb_uart_packet_tx;

   localparam int C = 4;

   logic       clk_3125 = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [31:0] data_flat;
   logic [2:0] byte_count;
   logic       parity_type;
   logic [2:0] tx_v, busy_v, bd_v, done_v;

   always #5 clk_3125 = ~clk_3125;

   // 0: no gap, no parity
   uart_packet_tx #(.NUM_BYTES(4), .CLKS_PER_BIT(C), .GAP_CYCLES(0), .PARITY_EN(0)) dut_a (
      .clk_3125(clk_3125), .rst(rst), .start(start_v[0]), .data_flat(data_flat),
      .byte_count(byte_count), .parity_type(parity_type),
      .tx(tx_v[0]), .busy(busy_v[0]), .byte_done(bd_v[0]), .done(done_v[0]));

   // 1: five idle cycles between bytes
   uart_packet_tx #(.NUM_BYTES(4), .CLKS_PER_BIT(C), .GAP_CYCLES(5), .PARITY_EN(0)) dut_b (
      .clk_3125(clk_3125), .rst(rst), .start(start_v[1]), .data_flat(data_flat),
      .byte_count(byte_count), .parity_type(parity_type),
      .tx(tx_v[1]), .busy(busy_v[1]), .byte_done(bd_v[1]), .done(done_v[1]));

   // 2: parity enabled
   uart_packet_tx #(.NUM_BYTES(4), .CLKS_PER_BIT(C), .GAP_CYCLES(0), .PARITY_EN(1)) dut_c (
      .clk_3125(clk_3125), .rst(rst), .start(start_v[2]), .data_flat(data_flat),
      .byte_count(byte_count), .parity_type(parity_type),
      .tx(tx_v[2]), .busy(busy_v[2]), .byte_done(bd_v[2]), .done(done_v[2]));

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic       tx_log[512];

   task automatic check(input string name, input string tag,
                        input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s_%s observed=%0h expected=%0h", name, tag, obs, exp);
      end
   endtask

   // Launch one packet on instance sel and check framing and timing of n frames
   task automatic run_packet(input int sel, input logic [2:0] cnt, input int n,
                             input int f, input int g, input bit disturb,
                             input string name);
      int         t_done, lim, done_idx, done_cnt, bd_cnt, low_cnt, s;
      logic       busy_at_t, busy_after;
      logic [10:0] fb;
      logic [7:0] exp_b;
      bit         ok;

      for (int b = 0; b < n; b++) exp_q.push_back(data_flat[8*b +: 8]);
      t_done = (n == 0) ? 0 : n*f*C + (n-1)*g;
      lim    = t_done + 6;
      done_idx = -1; done_cnt = 0; bd_cnt = 0; low_cnt = 0;
      busy_at_t = 1'b0; busy_after = 1'b1;

      @(negedge clk_3125);
      byte_count  = cnt;
      start_v[sel] = 1'b1;
      @(negedge clk_3125);
      start_v[sel] = 1'b0;

      for (int i = 0; i <= lim; i++) begin
         if (i > 0) @(negedge clk_3125);
         if (disturb && i == 20) begin
            start_v[sel] = 1'b1;
            data_flat    = ~data_flat;
            byte_count   = 3'd4;
         end
         if (disturb && i == 24) start_v[sel] = 1'b0;
         tx_log[i] = tx_v[sel];
         if (done_v[sel]) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
         if (bd_v[sel]) bd_cnt++;
         if (!tx_v[sel]) low_cnt++;
         if (i == t_done) busy_at_t = busy_v[sel];
         if (i == t_done + 1) busy_after = busy_v[sel];
      end

      check(name, "done_at", done_idx, t_done);
      check(name, "done_cnt", done_cnt, 1);
      check(name, "busy_at_done", busy_at_t, 1);
      check(name, "busy_after", busy_after, 0);
      check(name, "byte_done_cnt", bd_cnt, n);
      check(name, "busy_end", busy_v[sel], 0);
      if (n == 0) check(name, "tx_low_cycles", low_cnt, 0);

      for (int b = 0; b < n; b++) begin
         s  = b * (f*C + g);
         fb = '0;
         ok = 1'b1;
         for (int j = 0; j < f; j++) begin
            fb[j] = tx_log[s + j*C + C/2];
            for (int m = 0; m < C; m++)
               if (tx_log[s + j*C + m] !== fb[j]) ok = 1'b0;
         end
         exp_b = exp_q.pop_front();
         check(name, "start_bit", fb[0], 0);
         check(name, "data", fb[8:1], exp_b);
         if (f == 11) check(name, "parity", fb[9], (^exp_b) ^ parity_type);
         check(name, "stop_bit", fb[f-1], 1);
         check(name, "bit_width", ok, 1);
         if (b < n-1 && g > 0) begin
            ok = 1'b1;
            for (int m = 0; m < g; m++)
               if (tx_log[s + f*C + m] !== 1'b1) ok = 1'b0;
            check(name, "gap_high", ok, 1);
         end
      end
      $display("[TB] packet %s: %0d frames, done at +%0d", name, n, done_idx);
   endtask

   initial begin
      int low_cnt, done_cnt;

      rst = 1'b1; start_v = '0; data_flat = '0; byte_count = '0; parity_type = 1'b0;
      repeat (3) @(negedge clk_3125);
      for (int s = 0; s < 3; s++) begin
         check("reset", "tx", tx_v[s], 1);
         check("reset", "busy", busy_v[s], 0);
         check("reset", "done", done_v[s], 0);
         check("reset", "byte_done", bd_v[s], 0);
      end
      rst = 1'b0;

      // Single byte, plain framing
      data_flat = 32'h0000_00A5;
      run_packet(0, 3'd1, 1, 10, 0, 1'b0, "a5");

      // Parity, odd then even
      data_flat = 32'h0000_0003;
      parity_type = 1'b1;
      run_packet(2, 3'd1, 1, 11, 0, 1'b0, "par_odd");
      parity_type = 1'b0;
      run_packet(2, 3'd1, 1, 11, 0, 1'b0, "par_even");
      data_flat = 32'h0000_B4E1;
      parity_type = 1'b1;
      run_packet(2, 3'd2, 2, 11, 0, 1'b0, "par_two");
      parity_type = 1'b0;

      // Three bytes with inter-byte gap
      data_flat = 32'h00C3_3CA5;
      run_packet(1, 3'd3, 3, 10, 5, 1'b0, "gap3");

      // Inputs changed and start re-asserted while busy
      data_flat = 32'h1122_5A96;
      run_packet(0, 3'd2, 2, 10, 0, 1'b1, "snap");

      // Reset during the data bits of byte 1
      data_flat = 32'h0000_F00F;
      @(negedge clk_3125);
      byte_count = 3'd2; start_v[0] = 1'b1;
      @(negedge clk_3125);
      start_v[0] = 1'b0;
      repeat (55) @(negedge clk_3125);
      check("midrst", "busy_before", busy_v[0], 1);
      rst = 1'b1;
      @(negedge clk_3125);
      rst = 1'b0;
      check("midrst", "tx", tx_v[0], 1);
      check("midrst", "busy", busy_v[0], 0);
      check("midrst", "done", done_v[0], 0);
      low_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_3125);
         if (!tx_v[0]) low_cnt++;
         if (done_v[0]) done_cnt++;
      end
      check("midrst", "no_done", done_cnt, 0);
      check("midrst", "tx_idle", low_cnt, 0);
      data_flat = 32'h0000_7E81;
      run_packet(0, 3'd2, 2, 10, 0, 1'b0, "post_rst");

      // Reset and start together: reset wins
      @(negedge clk_3125);
      rst = 1'b1; start_v[0] = 1'b1;
      @(negedge clk_3125);
      rst = 1'b0; start_v[0] = 1'b0;
      check("rst_start", "busy", busy_v[0], 0);
      check("rst_start", "tx", tx_v[0], 1);
      @(negedge clk_3125);
      check("rst_start", "busy_later", busy_v[0], 0);

      // Empty packet
      run_packet(0, 3'd0, 0, 10, 0, 1'b0, "zero");

      // Oversized count clamps to NUM_BYTES
      data_flat = 32'h8001_FF7E;
      run_packet(0, 3'd7, 4, 10, 0, 1'b0, "clamp");

      check("scoreboard", "empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
